mask_bbox: RTL and testbench

MASK_BBOX -- requirements
Module: mask_bbox

---
 rtl/mask_bbox_pkg.sv | 12 +
 rtl/mask_bbox_minmax.sv | 27 ++
 rtl/mask_bbox.sv | 135 +++++++++++++
 tb/tb_mask_bbox.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mask_bbox_pkg.sv
// Shared definitions for the mask bounding-box block: FSM encoding and mask threshold bit.
package mask_bbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } bboxState_t;

  localparam int unsigned MaskBit = 7;

endpackage

// File: rtl/mask_bbox_minmax.sv
// One-axis min/max tracker: init loads an empty range, update widens it to include iPos.
module mask_minmax #(
  parameter int unsigned W = 8
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iInit,
  input  logic         iUpdate,
  input  logic [W-1:0] iPos,
  output logic [W-1:0] oMin,
  output logic [W-1:0] oMax
);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oMin <= '0;
      oMax <= '0;
    end else if (iInit) begin
      oMin <= '1;
      oMax <= '0;
    end else if (iUpdate) begin
      if (iPos < oMin) oMin <= iPos;
      if (iPos > oMax) oMax <= iPos;
    end
  end

endmodule

// File: rtl/mask_bbox.sv
// Per-frame bounding box and pixel count of a binary skin mask, published once per frame.
module mask_bbox
  import mask_bbox_pkg::*;
#(
  parameter int unsigned W_X       = 11,
  parameter int unsigned W_Y       = 10,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [7:0]       iY,
  input  logic             iHSync,
  input  logic             iVSync,
  input  logic             iLineValid,
  input  logic             iFrameValid,
  output logic [W_X-1:0]   oXMin,
  output logic [W_X-1:0]   oXMax,
  output logic [W_Y-1:0]   oYMin,
  output logic [W_Y-1:0]   oYMax,
  output logic [W_X+W_Y-1:0] oCount,
  output logic             oDetect,
  output logic             oValid
);

  localparam int unsigned W_C = W_X + W_Y;

  bboxState_t     state;
  logic           fvPrev;
  logic           lvPrev;
  logic           pendStart;
  logic [W_X-1:0] x;
  logic [W_Y-1:0] y;
  logic [W_C-1:0] count;
  logic [W_X-1:0] xMin;
  logic [W_X-1:0] xMax;
  logic [W_Y-1:0] yMin;
  logic [W_Y-1:0] yMax;

  logic fvRise;
  logic lvFall;
  logic accInit;
  logic maskHit;
  logic nonEmpty;
  logic unusedInputs;

  // A rise seen during DONE is remembered so the following IDLE cycle still starts the frame.
  assign fvRise   = iFrameValid && !fvPrev;
  assign lvFall   = lvPrev && !iLineValid;
  assign accInit  = (state == IDLE) && iFrameValid && (!fvPrev || pendStart);
  assign maskHit  = (state == ACTIVE) && iFrameValid && iLineValid && iY[MaskBit];
  assign nonEmpty = (count != '0);

  assign unusedInputs = ^{iHSync, iVSync, iY[6:0]};

  mask_minmax #(.W(W_X)) uXAxis (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iInit   (accInit),
    .iUpdate (maskHit),
    .iPos    (x),
    .oMin    (xMin),
    .oMax    (xMax)
  );

  mask_minmax #(.W(W_Y)) uYAxis (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iInit   (accInit),
    .iUpdate (maskHit),
    .iPos    (y),
    .oMin    (yMin),
    .oMax    (yMax)
  );

  // fvPrev resets high so a frame already in progress at release is skipped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      fvPrev    <= 1'b1;
      lvPrev    <= 1'b0;
      pendStart <= 1'b0;
      x         <= '0;
      y         <= '0;
      count     <= '0;
      oXMin     <= '0;
      oXMax     <= '0;
      oYMin     <= '0;
      oYMax     <= '0;
      oCount    <= '0;
      oDetect   <= 1'b0;
      oValid    <= 1'b0;
    end else begin
      fvPrev <= iFrameValid;
      lvPrev <= iLineValid;
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          pendStart <= 1'b0;
          if (accInit) begin
            state <= ACTIVE;
            x     <= '0;
            y     <= '0;
            count <= '0;
          end
        end
        ACTIVE: begin
          if (!iFrameValid) begin
            state <= DONE;
          end else begin
            if (lvFall) begin
              x <= '0;
              if (y != '1) y <= y + W_Y'(1);
            end else if (iLineValid && x != '1) begin
              x <= x + W_X'(1);
            end
            if (maskHit && count != '1) count <= count + W_C'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          pendStart <= fvRise;
          oValid    <= 1'b1;
          oXMin     <= nonEmpty ? xMin : '0;
          oXMax     <= nonEmpty ? xMax : '0;
          oYMin     <= nonEmpty ? yMin : '0;
          oYMax     <= nonEmpty ? yMax : '0;
          oCount    <= count;
          oDetect   <= (W_C+1)'(count) >= (W_C+1)'(MIN_COUNT);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_bbox.sv
// Scoreboard bench for mask_bbox: three instances (MIN_COUNT 64/8/9) share one directed stimulus.
module tb_mask_bbox;

  typedef struct {
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
    int d64;
    int d8;
    int d9;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  iY;
  logic        iHSync;
  logic        iVSync;
  logic        iLineValid;
  logic        iFrameValid;
  logic [10:0] oXMin [3];
  logic [10:0] oXMax [3];
  logic [9:0]  oYMin [3];
  logic [9:0]  oYMax [3];
  logic [20:0] oCount [3];
  logic        oDetect [3];
  logic        oValid [3];

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t expQ[$];
  exp_t last;
  logic prevValid;

  mask_bbox #(.W_X(11), .W_Y(10), .MIN_COUNT(64)) dut64 (
    .iClk(clk), .iRst_n(rst_n), .iY(iY), .iHSync(iHSync), .iVSync(iVSync),
    .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .oXMin(oXMin[0]), .oXMax(oXMax[0]), .oYMin(oYMin[0]), .oYMax(oYMax[0]),
    .oCount(oCount[0]), .oDetect(oDetect[0]), .oValid(oValid[0]));

  mask_bbox #(.W_X(11), .W_Y(10), .MIN_COUNT(8)) dut8 (
    .iClk(clk), .iRst_n(rst_n), .iY(iY), .iHSync(iHSync), .iVSync(iVSync),
    .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .oXMin(oXMin[1]), .oXMax(oXMax[1]), .oYMin(oYMin[1]), .oYMax(oYMax[1]),
    .oCount(oCount[1]), .oDetect(oDetect[1]), .oValid(oValid[1]));

  mask_bbox #(.W_X(11), .W_Y(10), .MIN_COUNT(9)) dut9 (
    .iClk(clk), .iRst_n(rst_n), .iY(iY), .iHSync(iHSync), .iVSync(iVSync),
    .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .oXMin(oXMin[2]), .oXMax(oXMax[2]), .oYMin(oYMin[2]), .oYMax(oYMax[2]),
    .oCount(oCount[2]), .oDetect(oDetect[2]), .oValid(oValid[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mkExp(input int xmin, input int xmax, input int ymin, input int ymax,
                                 input int cnt, input int d64, input int d8, input int d9);
    exp_t e;
    e.xmin = xmin; e.xmax = xmax; e.ymin = ymin; e.ymax = ymax;
    e.cnt = cnt; e.d64 = d64; e.d8 = d8; e.d9 = d9;
    return e;
  endfunction

  // Drive one w x h frame; mask is the rectangle (x0..x1, y0..y1) when en is set.
  task automatic runFrame(input int w, input int h, input int x0, input int x1,
                          input int y0, input int y1, input bit en);
    iFrameValid = 1'b1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        iLineValid = 1'b1;
        iY = (en && c >= x0 && c <= x1 && r >= y0 && r <= y1) ? 8'd255 : 8'd0;
        @(negedge clk);
      end
      iLineValid = 1'b0;
      iY = 8'd0;
      repeat (2) @(negedge clk);
    end
    iFrameValid = 1'b0;
  endtask

  task automatic checkOutputsZero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_xmin"}, 32'(oXMin[i]), 0);
      chk({nm, "_ymax"}, 32'(oYMax[i]), 0);
      chk({nm, "_count"}, 32'(oCount[i]), 0);
      chk({nm, "_valid"}, 32'(oValid[i]), 0);
    end
    chk({nm, "_xmax"}, 32'(oXMax[0]), 0);
    chk({nm, "_ymin"}, 32'(oYMin[0]), 0);
    chk({nm, "_detect"}, 32'(oDetect[1]), 0);
  endtask

  // Monitor: pops the scoreboard on every oValid, otherwise requires outputs to hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last      = mkExp(0, 0, 0, 0, 0, 0, 0, 0);
      prevValid = 1'b0;
    end else begin
      chk("valid_align8", 32'(oValid[1]), 32'(oValid[0]));
      chk("valid_align9", 32'(oValid[2]), 32'(oValid[0]));
      if (oValid[0]) begin
        chk("valid_pulse_width", 32'(prevValid), 0);
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_valid: got oValid=1, expected no result pending (t=%0t)", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("xmin", 32'(oXMin[0]), e.xmin);
          chk("xmax", 32'(oXMax[0]), e.xmax);
          chk("ymin", 32'(oYMin[0]), e.ymin);
          chk("ymax", 32'(oYMax[0]), e.ymax);
          chk("count", 32'(oCount[0]), e.cnt);
          chk("detect64", 32'(oDetect[0]), e.d64);
          chk("detect8", 32'(oDetect[1]), e.d8);
          chk("detect9", 32'(oDetect[2]), e.d9);
          last = e;
        end
      end else begin
        chk("hold_xmin", 32'(oXMin[0]), last.xmin);
        chk("hold_xmax", 32'(oXMax[0]), last.xmax);
        chk("hold_ymin", 32'(oYMin[0]), last.ymin);
        chk("hold_ymax", 32'(oYMax[0]), last.ymax);
        chk("hold_count", 32'(oCount[0]), last.cnt);
        chk("hold_detect8", 32'(oDetect[1]), last.d8);
      end
      prevValid = oValid[0];
    end
  end

  initial begin
    rst_n       = 1'b0;
    iY          = 8'd0;
    iHSync      = 1'b0;
    iVSync      = 1'b0;
    iLineValid  = 1'b0;
    iFrameValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutputsZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Line activity outside a frame must be ignored.
    iLineValid = 1'b1;
    iY = 8'd255;
    repeat (5) @(negedge clk);
    iLineValid = 1'b0;
    iY = 8'd0;
    repeat (3) @(negedge clk);

    expQ.push_back(mkExp(2, 5, 1, 2, 8, 0, 1, 0));
    runFrame(8, 4, 2, 5, 1, 2, 1'b1);
    repeat (6) @(negedge clk);

    expQ.push_back(mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    runFrame(8, 4, 0, 7, 0, 3, 1'b0);
    repeat (6) @(negedge clk);

    expQ.push_back(mkExp(0, 0, 0, 0, 1, 0, 0, 0));
    runFrame(8, 4, 0, 0, 0, 0, 1'b1);
    repeat (6) @(negedge clk);

    expQ.push_back(mkExp(7, 7, 3, 3, 1, 0, 0, 0));
    runFrame(8, 4, 7, 7, 3, 3, 1'b1);
    repeat (6) @(negedge clk);

    // Exactly MIN_COUNT=64 mask pixels on the default instance.
    expQ.push_back(mkExp(0, 15, 0, 3, 64, 1, 1, 1));
    runFrame(16, 4, 0, 15, 0, 3, 1'b1);
    repeat (6) @(negedge clk);

    // Reset in row 2 with iFrameValid held high through release: that frame yields nothing.
    iFrameValid = 1'b1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      iLineValid = 1'b1;
      iY = 8'd255;
      repeat (8) @(negedge clk);
      iLineValid = 1'b0;
      iY = 8'd0;
      repeat (2) @(negedge clk);
    end
    iLineValid = 1'b1;
    iY = 8'd255;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutputsZero("async_reset");
    @(negedge clk);
    iLineValid = 1'b0;
    iY = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      iLineValid = 1'b1;
      iY = 8'd255;
      repeat (8) @(negedge clk);
      iLineValid = 1'b0;
      iY = 8'd0;
      repeat (2) @(negedge clk);
    end
    iFrameValid = 1'b0;
    repeat (10) @(negedge clk);

    expQ.push_back(mkExp(1, 6, 0, 3, 24, 0, 1, 1));
    runFrame(8, 4, 1, 6, 0, 3, 1'b1);
    repeat (6) @(negedge clk);

    // Back-to-back frames separated by a single idle cycle.
    expQ.push_back(mkExp(3, 3, 0, 3, 4, 0, 0, 0));
    runFrame(8, 4, 3, 3, 0, 3, 1'b1);
    @(negedge clk);
    expQ.push_back(mkExp(0, 7, 2, 2, 8, 0, 1, 0));
    runFrame(8, 4, 0, 7, 2, 2, 1'b1);

    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", expQ.size(), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
